// File: rtl/pclk_pll_seq_pkg.sv
// Shared definitions for the pixel-clock PLL sequencer.
//
// Contents:
//   state_t       - sequencer FSM states (3-bit encoding)
//   cnt_width()   - width needed for a counter that holds the values 0..n-1
//   DEF_*         - default parameter values and the counter widths derived from them
package pclk_pll_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HOLD     = 3'd1,
        ST_SHIFT    = 3'd2,
        ST_RELEASE  = 3'd3,
        ST_LOCKWAIT = 3'd4,
        ST_RUN      = 3'd5,
        ST_FAIL     = 3'd6
    } state_t;

    // A counter that only ever holds 0..n-1 needs $clog2(n) bits, and at least one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_CFG_BITS     = 26;
    localparam int DEF_SCLK_DIV     = 4;
    localparam int DEF_RESET_CYCLES = 64;
    localparam int DEF_LOCK_TIMEOUT = 1048576;

    localparam int DEF_RST_CNT_W  = cnt_width(DEF_RESET_CYCLES);
    localparam int DEF_LOCK_CNT_W = cnt_width(DEF_LOCK_TIMEOUT);
    localparam int DEF_PH_CNT_W   = cnt_width(2 * DEF_SCLK_DIV);
    localparam int DEF_BIT_CNT_W  = cnt_width(DEF_CFG_BITS);

endpackage

// File: rtl/pclk_pll_seq_if.sv
// Control-register side of the PLL sequencer.
//
// Signals:
//   start      - 1-cycle (re)configure request
//   cfg_word   - PLL config word, shifted out MSB first
//   bypass_req - request PLL bypass (no lock wait)
//   busy       - sequence in progress
//   done       - 1-cycle pulse on successful completion
//   error      - sticky lock failure flag
//   readback   - word shifted back out of the PLL during the last config shift
// Modports: master = register block, slave = sequencer.
interface pclk_pll_seq_if #(
    parameter int CFG_BITS = 26
) ();
    logic                start;
    logic [CFG_BITS-1:0] cfg_word;
    logic                bypass_req;
    logic                busy;
    logic                done;
    logic                error;
    logic [CFG_BITS-1:0] readback;

    modport master (
        output start, cfg_word, bypass_req,
        input  busy, done, error, readback
    );

    modport slave (
        input  start, cfg_word, bypass_req,
        output busy, done, error, readback
    );
endinterface

// File: rtl/pclk_pll_seq_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous level into the clk domain.
//
// Ports:
//   clk   - destination clock
//   reset - synchronous, active-high; clears both flops to 0
//   d     - asynchronous input
//   q     - synchronised output (two clk cycles of latency)
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pclk_pll_seq.sv
// Pixel-clock PLL sequencer.
//
// On an accepted start it holds the PLL and the pixel domain in reset, shifts a config
// word into the PLL serial port (reading the PLL's serial output back at the same time),
// releases the PLL, waits for lock and finally releases the pixel-domain reset.
//
// Ports:
//   clk, reset     - system clock, synchronous active-high reset
//   ctl            - control-register interface (slave modport)
//   pll_nreset     - PLL reset, active-low
//   pll_bypass     - PLL bypass select
//   pll_sclk       - PLL config serial clock
//   pll_sdi        - PLL config serial data in
//   pll_sdo        - PLL config serial data out (asynchronous)
//   pll_locked     - PLL lock indicator (asynchronous)
//   pclk_reset_req - pixel-domain reset request, active-high
//
// Build option: define LOCK_MONITOR_EN to treat loss of lock while running as a failure.
module pclk_pll_seq
    import pclk_pll_seq_pkg::*;
#(
    parameter int CFG_BITS     = DEF_CFG_BITS,
    parameter int SCLK_DIV     = DEF_SCLK_DIV,
    parameter int RESET_CYCLES = DEF_RESET_CYCLES,
    parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    pclk_pll_seq_if.slave ctl,
    output logic          pll_nreset,
    output logic          pll_bypass,
    output logic          pll_sclk,
    output logic          pll_sdi,
    input  logic          pll_sdo,
    input  logic          pll_locked,
    output logic          pclk_reset_req
);
    // One down-counter is shared between the HOLD interval and the sclk bit period.
    localparam int RST_W  = cnt_width(RESET_CYCLES);
    localparam int PH_W   = cnt_width(2 * SCLK_DIV);
    localparam int CNT_W  = (RST_W > PH_W) ? RST_W : PH_W;
    localparam int LOCK_W = cnt_width(LOCK_TIMEOUT);
    localparam int BIT_W  = cnt_width(CFG_BITS);

    localparam logic [CNT_W-1:0]  CNT_HOLD  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_BIT   = CNT_W'(2 * SCLK_DIV - 1);
    localparam logic [CNT_W-1:0]  CNT_HALF  = CNT_W'(SCLK_DIV);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_TIMEOUT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(CFG_BITS - 1);

    state_t              state, state_d;
    logic [CNT_W-1:0]    cnt, cnt_d, cnt_dec;
    logic [LOCK_W-1:0]   lock_cnt, lock_cnt_d;
    logic [BIT_W-1:0]    bit_cnt, bit_cnt_d;
    logic [CFG_BITS-1:0] cfg_sh, cfg_sh_d;
    logic [CFG_BITS-2:0] shadow, shadow_d;
    logic [CFG_BITS-1:0] rb_q, rb_d;
    logic busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic nreset_q, nreset_d, bypass_q, bypass_d, sclk_q, sclk_d, sdi_q, sdi_d, req_q, req_d;
    logic locked_sync, sdo_sync;

    sync_2ff u_sync_locked (.clk(clk), .reset(reset), .d(pll_locked), .q(locked_sync));
    sync_2ff u_sync_sdo    (.clk(clk), .reset(reset), .d(pll_sdo),    .q(sdo_sync));

`ifdef LOCK_MONITOR_EN
    logic locked_prev;

    always_ff @(posedge clk) begin
        if (reset) locked_prev <= 1'b0;
        else       locked_prev <= locked_sync;
    end
`endif

    always_comb begin
        state_d    = state;
        cnt_d      = cnt;
        lock_cnt_d = lock_cnt;
        bit_cnt_d  = bit_cnt;
        cfg_sh_d   = cfg_sh;
        shadow_d   = shadow;
        rb_d       = rb_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        error_d    = error_q;
        nreset_d   = nreset_q;
        bypass_d   = bypass_q;
        sclk_d     = sclk_q;
        sdi_d      = sdi_q;
        req_d      = req_q;
        cnt_dec    = cnt - CNT_ONE;

        case (state)
            ST_IDLE, ST_RUN, ST_FAIL: begin
                if (ctl.start) begin
                    state_d  = ST_HOLD;
                    cnt_d    = CNT_HOLD;
                    cfg_sh_d = ctl.cfg_word;
                    bypass_d = ctl.bypass_req;
                    error_d  = 1'b0;
                    busy_d   = 1'b1;
                    nreset_d = 1'b0;
                    req_d    = 1'b1;
                    sclk_d   = 1'b0;
                    sdi_d    = 1'b0;
                end
`ifdef LOCK_MONITOR_EN
                else if (state == ST_RUN && locked_prev && !locked_sync) begin
                    state_d = ST_FAIL;
                    req_d   = 1'b1;
                    error_d = 1'b1;
                end
`endif
            end
            ST_HOLD: begin
                if (cnt == '0) begin
                    state_d   = ST_SHIFT;
                    cnt_d     = CNT_BIT;
                    bit_cnt_d = BIT_LAST;
                    sdi_d     = cfg_sh[CFG_BITS-1];
                end else begin
                    cnt_d = cnt_dec;
                end
            end
            ST_SHIFT: begin
                if (cnt == '0) begin
                    // Last cycle of the high phase: capture the PLL's output bit.
                    shadow_d = (CFG_BITS-1)'({shadow, sdo_sync});
                    sclk_d   = 1'b0;
                    if (bit_cnt == '0) begin
                        state_d  = ST_RELEASE;
                        rb_d     = {shadow, sdo_sync};
                        nreset_d = 1'b1;
                        sdi_d    = 1'b0;
                    end else begin
                        bit_cnt_d = bit_cnt - BIT_W'(1);
                        cfg_sh_d  = {cfg_sh[CFG_BITS-2:0], 1'b0};
                        sdi_d     = cfg_sh[CFG_BITS-2];
                        cnt_d     = CNT_BIT;
                    end
                end else begin
                    // sclk is low while the counter is in the upper half of the bit period.
                    cnt_d  = cnt_dec;
                    sclk_d = (cnt_dec < CNT_HALF);
                end
            end
            ST_RELEASE: begin
                if (bypass_q) begin
                    state_d = ST_RUN;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    state_d    = ST_LOCKWAIT;
                    lock_cnt_d = '0;
                end
            end
            ST_LOCKWAIT: begin
                // Lock takes priority over a simultaneous timeout.
                if (locked_sync) begin
                    state_d = ST_RUN;
                    req_d   = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (lock_cnt == LOCK_LAST) begin
                    state_d = ST_FAIL;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end else begin
                    lock_cnt_d = lock_cnt + LOCK_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            lock_cnt <= '0;
            bit_cnt  <= '0;
            rb_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            nreset_q <= 1'b0;
            bypass_q <= 1'b0;
            sclk_q   <= 1'b0;
            sdi_q    <= 1'b0;
            req_q    <= 1'b1;
        end else begin
            state    <= state_d;
            cnt      <= cnt_d;
            lock_cnt <= lock_cnt_d;
            bit_cnt  <= bit_cnt_d;
            rb_q     <= rb_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            nreset_q <= nreset_d;
            bypass_q <= bypass_d;
            sclk_q   <= sclk_d;
            sdi_q    <= sdi_d;
            req_q    <= req_d;
        end
    end

    // Shift data registers need no reset: they are loaded before they are used.
    always_ff @(posedge clk) begin
        cfg_sh <= cfg_sh_d;
        shadow <= shadow_d;
    end

    assign ctl.busy       = busy_q;
    assign ctl.done       = done_q;
    assign ctl.error      = error_q;
    assign ctl.readback   = rb_q;
    assign pll_nreset     = nreset_q;
    assign pll_bypass     = bypass_q;
    assign pll_sclk       = sclk_q;
    assign pll_sdi        = sdi_q;
    assign pclk_reset_req = req_q;
endmodule

// File: tb/tb_pclk_pll_seq.sv
// Testbench for pclk_pll_seq (CFG_BITS=8, SCLK_DIV=2, RESET_CYCLES=4, LOCK_TIMEOUT=16).
// A small PLL model captures sdi on sclk rise and presents it on sdo at sclk fall,
// so the word read back is the config word delayed by one bit.
module tb_pclk_pll_seq;
    localparam int N    = 8;
    localparam int D    = 2;
    localparam int R    = 4;
    localparam int T    = 16;
    localparam int EREL = R + 2 * D * N;   // cycle (after accept) at which the PLL is released

    logic clk = 1'b0;
    logic reset;
    logic pll_nreset, pll_bypass, pll_sclk, pll_sdi, pclk_reset_req;
    logic pll_sdo, pll_locked, cap;

    int n_vec = 0;
    int n_err = 0;
    logic [N-1:0] rb_model;

    always #5 clk = ~clk;

    pclk_pll_seq_if #(.CFG_BITS(N)) bus ();

    pclk_pll_seq #(
        .CFG_BITS(N), .SCLK_DIV(D), .RESET_CYCLES(R), .LOCK_TIMEOUT(T)
    ) dut (
        .clk(clk), .reset(reset), .ctl(bus),
        .pll_nreset(pll_nreset), .pll_bypass(pll_bypass), .pll_sclk(pll_sclk),
        .pll_sdi(pll_sdi), .pll_sdo(pll_sdo), .pll_locked(pll_locked),
        .pclk_reset_req(pclk_reset_req)
    );

    // PLL serial-port model.
    always @(posedge pll_sclk or negedge pll_sclk or posedge reset) begin
        if (reset) begin
            cap     = 1'b0;
            pll_sdo = 1'b0;
        end else if (pll_sclk) begin
            cap = pll_sdi;
        end else begin
            pll_sdo = cap;
        end
    end

    typedef struct {
        logic [N-1:0] cfg;
        logic         byp;
        int           lock_dly;   // cycles after PLL release until pll_locked rises; -1 = never
        bit           spur;       // throw extra start pulses while busy
        logic         exp_ok;
        logic [N-1:0] exp_rb;
    } vec_t;

    // {busy, done, error, pclk_reset_req, pll_nreset, pll_bypass, pll_sclk, pll_sdi, readback}
    function automatic logic [15:0] observed();
        return {bus.busy, bus.done, bus.error, pclk_reset_req, pll_nreset, pll_bypass,
                pll_sclk, pll_sdi, bus.readback};
    endfunction

    function automatic bit ends_ok(input logic byp, input int lk);
        return byp || (lk >= 0 && lk + 2 <= T);
    endfunction

    // First cycle (after accept) in which the sequencer is in RUN or FAIL.
    function automatic int end_cycle(input logic byp, input int lk);
        int lw;
        lw = EREL + 1;
        if (byp) return EREL + 1;
        if (ends_ok(byp, lk)) return ((EREL + lk + 2 > lw) ? EREL + lk + 2 : lw) + 1;
        return lw + T;
    endfunction

    function automatic logic [15:0] expected(input int e, input logic [N-1:0] cfg,
                                             input logic byp, input int lk,
                                             input logic [N-1:0] rb_old,
                                             input logic [N-1:0] rb_new);
        int   eend, p;
        bit   ok;
        logic sclk, sdi;
        eend = end_cycle(byp, lk);
        ok   = ends_ok(byp, lk);
        sclk = 1'b0;
        sdi  = 1'b0;
        if (e >= R && e < EREL) begin
            p    = e - R;
            sclk = ((p % (2 * D)) >= D);
            sdi  = cfg[N - 1 - p / (2 * D)];
        end
        return {logic'(e < eend), logic'(ok && e == eend), logic'(!ok && e >= eend),
                logic'(!(ok && e >= eend)), logic'(e >= EREL), byp, sclk, sdi,
                (e >= EREL) ? rb_new : rb_old};
    endfunction

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset      = 1'b1;
        bus.start  = 1'b0;
        pll_locked = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset    = 1'b0;
        rb_model = '0;
        @(negedge clk);
        check("reset_values", observed(), 16'h1000);
    endtask

    task automatic run_txn(input logic [N-1:0] cfg, input logic byp, input int lk,
                           input bit spur, output bit done_seen, output logic err_f,
                           output logic [N-1:0] rb_f);
        int           eend;
        logic [N-1:0] rb_new;
        eend      = end_cycle(byp, lk);
        rb_new    = rb_model;
        done_seen = 1'b0;
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.cfg_word   = cfg;
        bus.bypass_req = byp;
        pll_locked     = 1'b0;
        for (int e = 0; e <= eend + 3; e++) begin
            @(posedge clk);
            #1;
            bus.start  = spur && (e < eend) && ($urandom_range(0, 2) == 0);
            if (spur) begin
                bus.cfg_word   = N'($urandom);
                bus.bypass_req = $urandom_range(0, 1) == 1;
            end
            pll_locked = (lk >= 0) && (e >= EREL + lk);
            @(negedge clk);
            // The first bit read back is whatever the PLL presented before shifting began.
            if (e == R) rb_new = {pll_sdo, cfg[N-1:1]};
            check($sformatf("txn cfg=%h e=%0d", cfg, e), observed(),
                  expected(e, cfg, byp, lk, rb_model, rb_new));
            if (bus.done) done_seen = 1'b1;
        end
        err_f    = bus.error;
        rb_f     = bus.readback;
        rb_model = rb_new;
    endtask

    vec_t         vecs[6];
    bit           dseen;
    logic         errf;
    logic [N-1:0] rbf;

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.cfg_word   = '0;
        bus.bypass_req = 1'b0;
        pll_locked     = 1'b0;
        rb_model       = '0;

        vecs[0] = '{cfg: 8'hA5, byp: 1'b0, lock_dly: 5,  spur: 1'b0, exp_ok: 1'b1, exp_rb: 8'h52};
        vecs[1] = '{cfg: 8'h3C, byp: 1'b0, lock_dly: 3,  spur: 1'b1, exp_ok: 1'b1, exp_rb: 8'h1E};
        vecs[2] = '{cfg: 8'h5A, byp: 1'b0, lock_dly: -1, spur: 1'b0, exp_ok: 1'b0, exp_rb: 8'h2D};
        vecs[3] = '{cfg: 8'hC3, byp: 1'b1, lock_dly: -1, spur: 1'b1, exp_ok: 1'b1, exp_rb: 8'h61};
        vecs[4] = '{cfg: 8'h81, byp: 1'b0, lock_dly: 14, spur: 1'b0, exp_ok: 1'b1, exp_rb: 8'h40};
        vecs[5] = '{cfg: 8'h7E, byp: 1'b0, lock_dly: 15, spur: 1'b0, exp_ok: 1'b0, exp_rb: 8'h3F};

        for (int i = 0; i < 6; i++) begin
            do_reset();
            run_txn(vecs[i].cfg, vecs[i].byp, vecs[i].lock_dly, vecs[i].spur, dseen, errf, rbf);
            check($sformatf("tbl%0d done", i), 16'(dseen), 16'(vecs[i].exp_ok));
            check($sformatf("tbl%0d error", i), 16'(errf), 16'(!vecs[i].exp_ok));
            check($sformatf("tbl%0d readback", i), 16'(rbf), 16'(vecs[i].exp_rb));
        end

        // Reset in the middle of SHIFT, with bypass and a non-zero readback outstanding.
        do_reset();
        run_txn(8'h96, 1'b1, -1, 1'b0, dseen, errf, rbf);
        @(posedge clk);
        #1;
        bus.start      = 1'b1;
        bus.cfg_word   = 8'hF0;
        bus.bypass_req = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (R + 6) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("reset_mid_shift", observed(), 16'h1000);
        #1;
        reset    = 1'b0;
        rb_model = '0;

        // Loss of lock while running.
        do_reset();
        run_txn(8'h11, 1'b0, 2, 1'b0, dseen, errf, rbf);
        @(posedge clk);
        #1;
        pll_locked = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
`ifdef LOCK_MONITOR_EN
        check("lock_loss", observed(), 16'h3808);
`else
        check("lock_loss", observed(), 16'h0808);
`endif

        // Randomised back-to-back transactions restarting from RUN/FAIL.
        do_reset();
        for (int i = 0; i < 30; i++) begin
            logic [N-1:0] cfg;
            logic         byp;
            int           lk;
            cfg = N'($urandom);
            byp = ($urandom_range(0, 3) == 0);
            lk  = ($urandom_range(0, 5) == 0) ? -1 : int'($urandom_range(0, 20));
            run_txn(cfg, byp, lk, $urandom_range(0, 1) == 1, dseen, errf, rbf);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
